// File: rtl/pulse_param_loader.sv
// Pulse-sequencer parameter frame loader: SYNC + 17 payload bytes + checksum.
// Define PARAM_LOADER_ACK_EN to enable the ACK/NAK response byte on tx_*.
module pulse_param_loader #(
    parameter int         TIMEOUT   = 2_000_000,
    parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [23:0] per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic [7:0]  nut_w,
    output logic [15:0] nut_d,
    output logic [7:0]  cp,
    output logic [7:0]  p_bl,
    output logic [15:0] p_bl_off,
    output logic        bl,
    output logic        load,
    output logic [7:0]  frame_err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int NBYTES = 17;
    localparam int CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    // Payload image, byte 0 in the top bits, same order as on the wire.
    localparam logic [NBYTES*8-1:0] DEFAULTS = {
        24'h010000, 16'd30, 16'd200, 16'd30, 8'd50,
        16'd300, 8'd3, 8'd50, 16'd100, 8'd1
    };

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [7:0]            sum_q, sum_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NBYTES*8-1:0]   shadow_q, shadow_d;
    logic [NBYTES*8-1:0]   params_q, params_d;
    logic                  load_q, load_d;
    logic [7:0]            err_q, err_d;

    logic [7:0] sum_next;
    logic       in_frame;
    logic       reject;
    logic       ack_ev;
    logic       nak_ev;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        params_d = params_q;
        load_d   = 1'b0;
        err_d    = err_q;
        reject   = 1'b0;
        ack_ev   = 1'b0;
        nak_ev   = 1'b0;
        sum_next = sum_q + rx_data;
        in_frame = (state_q == PAYLOAD) || (state_q == CHECK);

        unique case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = 5'd0;
                    sum_d   = 8'd0;
                    cnt_d   = '0;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_q == 5'(i)) begin
                            shadow_d[(NBYTES-1-i)*8 +: 8] = rx_data;
                        end
                    end
                    sum_d = sum_next;
                    cnt_d = '0;
                    if (idx_q == 5'(NBYTES - 1)) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (sum_next == 8'd0) begin
                        state_d  = COMMIT;
                        params_d = shadow_q;
                        load_d   = 1'b1;
                        ack_ev   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        reject  = 1'b1;
                        nak_ev  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte watchdog; abandons the partial frame.
        if (in_frame && !rx_valid) begin
            if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                reject  = 1'b1;
                nak_ev  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (reject && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 5'd0;
            sum_q    <= 8'd0;
            cnt_q    <= '0;
            shadow_q <= DEFAULTS;
            params_q <= DEFAULTS;
            load_q   <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            params_q <= params_d;
            load_q   <= load_d;
            err_q    <= err_d;
        end
    end

    assign {per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off} =
        params_q[NBYTES*8-1:8];
    assign bl        = params_q[0];
    assign load      = load_q;
    assign frame_err = err_q;

    logic unused_bl;
    assign unused_bl = |params_q[7:1];

`ifdef PARAM_LOADER_ACK_EN
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;

    // Single-entry response slot; a newer verdict replaces an unsent one.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (ack_ev) begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h06;
        end else if (nak_ev) begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h15;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
`else
    assign tx_valid = 1'b0;
    assign tx_data  = 8'h00;

    logic unused_ack;
    assign unused_ack = tx_ready ^ ack_ev ^ nak_ev;
`endif

endmodule

// File: tb/tb_pulse_param_loader.sv
// Directed bench for pulse_param_loader (short TIMEOUT override).
module tb_pulse_param_loader;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [23:0] per;
    logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
    logic [7:0]  nut_w, cp, p_bl, frame_err, tx_data;
    logic        bl, load, tx_valid;

    int tests = 0;
    int fails = 0;
    int loads = 0;
    int hs = 0;

    logic [7:0] q[$];
    logic [7:0] pay[17];

    localparam logic [135:0] P1 =
        136'h000200_0028_012C_0028_10_0064_01_20_0050_01;
    localparam logic [135:0] P3 =
        136'h123456_0001_0002_0003_04_0005_06_07_0008_03;
    localparam logic [135:0] P4 =
        136'hAA0001_00AA_00AA_0005_AA_0100_02_AA_00AA_AA;

    pulse_param_loader #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl),
        .p_bl_off(p_bl_off), .bl(bl), .load(load),
        .frame_err(frame_err), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load) loads++;
    always @(posedge clk) if (tx_valid && tx_ready) hs++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string t,
                           input logic [31:0] e_per, e_p1, e_del, e_p2,
                           input logic [31:0] e_nw, e_nd, e_cp, e_pbl,
                           input logic [31:0] e_pblo, e_bl);
        chk({t, "_per"}, per, e_per);
        chk({t, "_p1wid"}, p1wid, e_p1);
        chk({t, "_del"}, del, e_del);
        chk({t, "_p2wid"}, p2wid, e_p2);
        chk({t, "_nut_w"}, nut_w, e_nw);
        chk({t, "_nut_d"}, nut_d, e_nd);
        chk({t, "_cp"}, cp, e_cp);
        chk({t, "_p_bl"}, p_bl, e_pbl);
        chk({t, "_p_bl_off"}, p_bl_off, e_pblo);
        chk({t, "_bl"}, bl, e_bl);
    endtask

    task automatic exp_def(input string t);
        exp_out(t, 'h010000, 30, 200, 30, 50, 300, 3, 50, 100, 1);
    endtask

    task automatic set_pay(input logic [135:0] v);
        for (int i = 0; i < 17; i++) pay[i] = v[135-8*i -: 8];
    endtask

    function automatic logic [7:0] cks(input logic [7:0] adj);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 17; i++) s = s + pay[i];
        return 8'h00 - s + adj;
    endfunction

    task automatic push_frame(input logic [7:0] adj);
        q.push_back(8'hAA);
        for (int i = 0; i < 17; i++) q.push_back(pay[i]);
        q.push_back(cks(adj));
    endtask

    // gap = idle cycles between consecutive bytes
    task automatic send_q(input int gap);
        foreach (q[i]) begin
            @(negedge clk);
            rx_data  = q[i];
            rx_valid = 1'b1;
            if (gap > 0) begin
                @(negedge clk);
                rx_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        exp_def("rst");
        chk("rst_load", load, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);

        set_pay(P1);
        push_frame(8'd0);
        send_q(0);
        chk("t1_loads", loads, 1);
        exp_out("t1", 'h000200, 40, 300, 40, 16, 100, 1, 32, 80, 1);
        chk("t1_ferr", frame_err, 0);
`ifdef PARAM_LOADER_ACK_EN
        chk("t1_txv", tx_valid, 1);
        chk("t1_txd", tx_data, 8'h06);
`else
        chk("t1_txv", tx_valid, 0);
`endif

        push_frame(8'd1);
        send_q(0);
        chk("t2_loads", loads, 1);
        exp_out("t2", 'h000200, 40, 300, 40, 16, 100, 1, 32, 80, 1);
        chk("t2_ferr", frame_err, 1);
`ifdef PARAM_LOADER_ACK_EN
        chk("t2_txd", tx_data, 8'h15);
`else
        chk("t2_txd", tx_data, 0);
`endif

        do_reset();
        chk("t3_rst_loads", loads, 1);
        chk("t3_rst_ferr", frame_err, 0);
        set_pay(P3);
        q.push_back(8'hAA);
        for (int i = 0; i < 5; i++) q.push_back(pay[i]);
        send_q(0);
        repeat (TO + 10) @(negedge clk);
        chk("t3_to_ferr", frame_err, 1);
        chk("t3_to_loads", loads, 1);
        exp_def("t3_to");
        push_frame(8'd0);
        send_q(0);
        chk("t3_loads", loads, 2);
        exp_out("t3", 'h123456, 1, 2, 3, 4, 5, 6, 7, 8, 1);
        chk("t3_ferr", frame_err, 1);

        set_pay(P1);
        push_frame(8'd0);
        send_q(TO - 1);
        chk("slow_loads", loads, 3);
        chk("slow_ferr", frame_err, 1);
        exp_out("slow", 'h000200, 40, 300, 40, 16, 100, 1, 32, 80, 1);

        set_pay(P4);
        push_frame(8'd0);
        send_q(0);
        chk("t4_loads", loads, 4);
        exp_out("t4", 'hAA0001, 'hAA, 'hAA, 5, 'hAA, 'h100, 2, 'hAA,
                'hAA, 0);

        set_pay(P3);
        push_frame(8'd0);
        set_pay(P1);
        push_frame(8'd0);
        send_q(0);
        chk("b2b_loads", loads, 6);
        exp_out("b2b", 'h000200, 40, 300, 40, 16, 100, 1, 32, 80, 1);
        chk("b2b_ferr", frame_err, 1);

        do_reset();
        set_pay(P1);
        q.push_back(8'hAA);
        for (int i = 0; i < 10; i++) q.push_back(pay[i]);
        send_q(0);
        do_reset();
        exp_def("t5_rst");
        chk("t5_rst_loads", loads, 6);
        for (int i = 10; i < 17; i++) q.push_back(pay[i]);
        q.push_back(cks(8'd0));
        send_q(0);
        exp_def("t5_tail");
        chk("t5_tail_loads", loads, 6);
        chk("t5_tail_ferr", frame_err, 0);
        set_pay(P3);
        push_frame(8'd0);
        send_q(0);
        chk("t5_rec_loads", loads, 7);
        chk("t5_rec_per", per, 'h123456);

`ifdef PARAM_LOADER_ACK_EN
        do_reset();
        chk("ack_rst_txv", tx_valid, 0);
        tx_ready = 1'b0;
        hs = 0;
        set_pay(P1);
        push_frame(8'd0);
        set_pay(P3);
        push_frame(8'd0);
        send_q(0);
        chk("ack_loads", loads, 9);
        chk("ack_txv", tx_valid, 1);
        chk("ack_txd", tx_data, 8'h06);
        chk("ack_hs0", hs, 0);
        @(negedge clk);
        #2 tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ack_hs1", hs, 1);
        chk("ack_txv_done", tx_valid, 0);
        chk("ack_txd_done", tx_data, 8'h06);
        tx_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_param_loader.md
Name: pulse_param_loader

Overview:
- Host-side command deserializer that sits between the UART byte receiver and the pulse sequencer.
- Collects a fixed-format parameter frame, checks its checksum, and drives the sequencer's parameter bus.
- Raises a one-cycle load strobe when a valid frame commits; the sequencer latches the bus on that strobe.
- Partially received or corrupt frames never disturb the outputs.

Parameters:
- TIMEOUT, 2_000_000, max clk cycles allowed between consecutive bytes of one frame before abort (~10 ms at 200 MHz).
- SYNC_BYTE, 8'hAA, frame start marker.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- per  out  24  period in cycles
- p1wid  out  16  first pulse width
- del  out  16  inter-pulse delay
- p2wid  out  16  second pulse width
- nut_w  out  8  nutation pulse width
- nut_d  out  16  nutation pulse delay
- cp  out  8  mode / pi-pulse count
- p_bl  out  8  block lead time
- p_bl_off  out  16  block window width
- bl  out  1  blocking enable
- load  out  1  one-cycle commit strobe
- frame_err  out  8  saturating count of rejected frames
- tx_data  out  8  response byte (optional feature)
- tx_valid  out  1  response valid (optional feature)
- tx_ready  in  1  UART transmitter ready (optional feature)

Behaviour:
- Frame format: SYNC_BYTE, 17 payload bytes, 1 checksum byte.
  - Payload order, each field MSB first: per(3), p1wid(2), del(2), p2wid(2), nut_w(1), nut_d(2), cp(1), p_bl(1), p_bl_off(2), bl(1).
  - For bl, only bit 0 is used; bits 7:1 are ignored.
- Checksum rule: 8-bit mod-256 sum of all 17 payload bytes plus the checksum byte must equal 8'h00.
- Reset values:
  - per=24'h010000, p1wid=30, del=200, p2wid=30, nut_w=50, nut_d=300, cp=3, p_bl=50, p_bl_off=100, bl=1.
  - load=0, frame_err=0, tx_valid=0, tx_data=0.
  - State=IDLE, byte index=0, running sum=0, timeout counter=0.
- States:
  - IDLE: rx_valid with rx_data==SYNC_BYTE -> PAYLOAD (index=0, sum=0). Any other byte is dropped.
  - PAYLOAD: each rx_valid writes the byte into the shadow register selected by index, adds it to sum, and increments index. After index 16 is accepted -> CHECK. SYNC_BYTE values in the payload are plain data, not a resync.
  - CHECK: next rx_valid adds the checksum byte. If the result is 0 -> COMMIT; otherwise -> IDLE and frame_err increments (saturating at 255).
  - COMMIT: lasts one cycle. Copies shadow registers to outputs, asserts load=1 for that cycle, then -> IDLE.
- Commit timing: outputs change and load asserts in the cycle after the checksum byte's rx_valid. Outputs stay stable at all other times.
- Timeout: in PAYLOAD or CHECK, the counter resets on each rx_valid and increments otherwise. At TIMEOUT -> IDLE, frame_err increments, shadow contents are discarded.
- rx_valid in the COMMIT cycle is processed exactly as in IDLE.
- Reset mid-frame returns to IDLE and restores all output reset values. No load pulse is emitted on reset.
- Shadow registers reset to the same default values as the outputs.

Optional Feature:
- Macro: PARAM_LOADER_ACK_EN.
- Defined:
  - Each checksum pass queues tx_data=8'h06 (ACK).
  - Each checksum fail or timeout queues tx_data=8'h15 (NAK).
  - tx_valid is held until the cycle tx_valid && tx_ready; tx_valid deasserts the following cycle.
  - One-entry queue: a newer response overwrites an unsent one.
  - Frame reception never stalls on tx_ready.
- Undefined: tx_valid is tied 0, tx_data is tied 0, tx_ready is ignored, and no ACK logic is synthesised.

Test Plan:
- Reset, then send AA + payload {00 02 00, 00 28, 01 2C, 00 28, 10, 00 64, 01, 20, 00 50, 01} + correct checksum.
  - Response: one-cycle load; per=0x000200, p1wid=40, del=300, p2wid=40, nut_w=16, nut_d=100, cp=1, p_bl=32, p_bl_off=80, bl=1.
- Same frame with checksum+1.
  - Response: no load, outputs unchanged, frame_err=1. With ACK_EN, tx_data=8'h15.
- AA + 5 bytes, then idle TIMEOUT+10 cycles, then a valid frame.
  - Response: frame_err=1 after the timeout; second frame commits normally.
- Valid frame whose payload contains 8'hAA bytes.
  - Response: commits correctly, with the AA bytes landing in their fields.
- Assert reset after the 10th payload byte, then send the remaining bytes.
  - Response: outputs return to defaults, no load pulse; trailing bytes are ignored until the next AA.
- With ACK_EN and tx_ready=0, send 2 back-to-back valid frames, then raise tx_ready.
  - Response: 2 load pulses, one ACK byte (8'h06) transferred, tx_valid deasserts after the handshake.
